i2c_apb_arbiter: RTL

- Shares the I2C master's single APB register port between NUM_REQ independent requesters, such as the sequencer agent, the interrupt/status poller and the debug path.
- Each requester posts one register access (address, read/write, write data).
- The block arbitrates round-robin and drives a complete APB transfer (setup and access phases, waits on pready).
- It returns read data or a timeout error to the originating requester.

---
 rtl/i2c_apb_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_apb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_apb_arbiter
//  Purpose  : Shares the I2C master's single APB register port between
//             NUM_REQ requesters. Round-robin grant, one APB transfer in
//             flight, read data or timeout error returned to the requester.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_apb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                        apb_clk,
  input  logic                        reset,
  // requester side
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  // APB master side
  output logic [ADDR_W-1:0]           paddr,
  output logic                        pwrite,
  output logic                        psel,
  output logic                        penable,
  output logic [DATA_W-1:0]           pwdata,
  input  logic [DATA_W-1:0]           prdata,
  input  logic                        pready,
  // status
  output logic                        busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_FIRST = CNT_W'(1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e              state_q,  state_d;
  logic [IDX_W-1:0]    ptr_q,    ptr_d;
  logic [IDX_W-1:0]    grant_q,  grant_d;
  logic [ADDR_W-1:0]   paddr_q,  paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W-1:0]   rdata_q,  rdata_d;
  logic                err_q,    err_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;

  // Arbitration results
  logic                hi_found, lo_found, win_found;
  logic [IDX_W-1:0]    hi_idx,   lo_idx,   win_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_write;
  logic [DATA_W-1:0]   sel_wdata;

  // Round-robin search: lowest request at or above the pointer, else wrap
  // around to the lowest request overall; then mux the winner's command.
  always_comb begin
    hi_found  = 1'b0;
    hi_idx    = '0;
    lo_found  = 1'b0;
    lo_idx    = '0;
    sel_addr  = '0;
    sel_write = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
      end
      if (req_valid[i] && !hi_found && (i >= int'(ptr_q))) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(i);
      end
    end
    win_found = hi_found | lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == win_idx) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_write = req_write[i];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Transfer FSM: next state, latched command/response and APB strobes
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    rsp_valid = '0;
    psel      = 1'b0;
    penable   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          req_ready = ONE_HOT0 << win_idx;
          grant_d   = win_idx;
          paddr_d   = sel_addr;
          pwrite_d  = sel_write;
          pwdata_d  = sel_wdata;
          ptr_d     = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        psel    = 1'b1;
        cnt_d   = CNT_FIRST;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        // pready is tested first so it wins over a coinciding timeout
        if (pready) begin
          rdata_d = pwrite_q ? '0 : prdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LIMIT)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid = ONE_HOT0 << grant_q;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // No grant may be offered while reset is being applied
    if (reset) begin
      req_ready = '0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge apb_clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
